jttrack_gfx_arb: RTL and testbench
==================================

# jttrack_gfx_arb

Two-requester arbiter that shares one 32-bit SDRAM graphics read port between the scroll tile fetcher and the object fetcher of the Track'n Field video. It sits between `jttrack_scroll`/`jttrack_obj` and the SDRAM controller slot. Each requester has a one-entry result cache, so repeated reads of the same word cost no SDRAM access.

## Interface
Parameters:
- `AW`, 15: SDRAM word-address width.
- `SCR_OFFSET`, 15'h0000: word offset added to scroll addresses.
- `OBJ_OFFSET`, 15'h4000: word offset added to object addresses.

Ports:
- `clk` in 1: 48 MHz system clock; the block's only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scr_cs` in 1: scroll read request.
- `scr_addr` in 14: scroll word address.
- `scr_data` out 32: scroll read data.
- `scr_ok` out 1: scroll data valid for the current `scr_addr`.
- `obj_cs` in 1: object read request.
- `obj_addr` in 14: object word address.
- `obj_data` out 32: object read data.
- `obj_ok` out 1: object data valid for the current `obj_addr`.
- `rom_cs` out 1: SDRAM request.
- `rom_addr` out AW: SDRAM word address.
- `rom_data` in 32: SDRAM data.
- `rom_ok` in 1: SDRAM data valid. Level signal, only meaningful while `rom_cs` is high.
- `busy` out 1: a fetch is outstanding (debug).

## Operation
- Per requester X ∈ {scr, obj}:
  - Registers: `X_tag[13:0]`, `X_vld`, `X_data[31:0]`.
  - `X_ok = X_cs & X_vld & (X_tag == X_addr)`. This is combinational, so it drops in the same cycle the address changes.
  - `X_data` is the registered `X_data`.
- A requester is pending when `X_cs & ~X_ok` and it is not the one currently being fetched.
- FSM states:
  - IDLE:
    - If any requester is pending, select a grantee.
    - Latch `gnt_addr = X_addr + X_OFFSET`; the sum is truncated to AW bits and wraps.
    - Go to FETCH.
  - FETCH:
    - `rom_cs = 1` and `rom_addr = gnt_addr`, both held stable.
    - On the first cycle with `rom_ok = 1`: write `X_data <= rom_data`, `X_tag <= latched X address`, `X_vld <= 1`. Go to IDLE.
- Grant policy with both pending in IDLE: scroll wins (fixed priority). See Configuration for the alternative.
- Address change during FETCH: the fetch is not aborted. The data is stored under the old tag, so `X_ok` stays low and X becomes pending again in IDLE.
- `X_cs` dropping during FETCH: the fetch still completes and fills the cache.
- Only a completed fetch changes the tag/valid registers; there is no other invalidation.

## Timing
- Reset values:
  - `rom_cs` = 0, `rom_addr` = 0, `busy` = 0.
  - `scr_ok` = `obj_ok` = 0; all `_vld` = 0.
  - `scr_data` = `obj_data` = 0.
  - FSM in IDLE.
- Miss latency:
  - Request seen in IDLE at cycle 0 → `rom_cs` high at cycle 1.
  - `rom_ok` at cycle N (N ≥ 1) → data registered at the N clock edge → `X_ok` high at cycle N+1.
  - `rom_cs` low at N+1.
- Back-to-back requests: the next grant is decided at cycle N+1 and its `rom_cs` rises at N+2. The minimum bubble on `rom_cs` is one cycle.
- Hit latency: 0 cycles (combinational), with no `rom_cs`.
- `busy` equals the FETCH state.
- Reset asserted mid-FETCH: `rom_cs` drops immediately (asynchronous reset) and the caches are invalidated.

## Configuration
- `JTTRACK_GFXARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit `last` register records the most recent grantee, and the other requester wins on a tie.
  - `last` resets to obj, so scroll wins the first tie.
- Not defined: fixed scroll priority and no `last` register.

## Test plan
- Single miss: `scr_cs`=1, `scr_addr`=14'h0123, SDRAM returns 32'hDEADBEEF with `rom_ok` 3 cycles after `rom_cs`.
  - Required: `rom_addr`=15'h0123.
  - Required: `scr_ok`=1 with `scr_data`=32'hDEADBEEF one cycle after `rom_ok`.
- Hit: repeat address 14'h0123 after the fill → `scr_ok` high in the same cycle, `rom_cs` never asserted.
- Offset wrap: `obj_addr`=14'h3FFF with `OBJ_OFFSET`=15'h4001 → `rom_addr`=15'h0000.
- Contention: `scr_cs` and `obj_cs` rise in the same cycle with different addresses.
  - Without the macro: scroll is served first, object second, with one idle cycle between the two `rom_cs` pulses.
  - With `JTTRACK_GFXARB_RR_EN`, after a previous scroll grant: object is served first.
- Address change mid-fetch: `scr_addr` goes 14'h0010 → 14'h0011 while in FETCH.
  - Required: the first fetch completes and `scr_ok` stays low.
  - Required: a second fetch to 15'h0011 follows, then `scr_ok`=1.
- Reset during FETCH: pull `rst_n` low while `rom_cs`=1 → `rom_cs`, `scr_ok`, `obj_ok` go to 0 immediately. After release, the old address misses again.

Source files
------------

// File: rtl/jttrack_gfx_arb.sv
// -----------------------------------------------------------------------------
// jttrack_gfx_arb
//
// Shares one 32-bit SDRAM graphics read port between the scroll tile fetcher
// and the object fetcher. Each requester keeps a one-entry result cache
// (tag, valid, data), so repeated reads of the same word are answered
// combinationally and cost no SDRAM access.
//
// Optional feature macro: JTTRACK_GFXARB_RR_EN
//   defined     -> round-robin arbitration on a tie (a 1-bit 'last' register,
//                  reset to obj so scroll wins the first tie)
//   not defined -> fixed priority, scroll wins every tie
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   scr_cs/scr_addr       scroll request and 14-bit word address
//   scr_data/scr_ok       scroll cached data, valid for the current scr_addr
//   obj_cs/obj_addr       object request and 14-bit word address
//   obj_data/obj_ok       object cached data, valid for the current obj_addr
//   rom_cs/rom_addr       SDRAM request and AW-bit word address
//   rom_data/rom_ok       SDRAM read data and data-valid level
//   busy                  a fetch is outstanding (debug)
// -----------------------------------------------------------------------------
module jttrack_gfx_arb #(
  parameter int              AW         = 15,
  parameter logic [AW-1:0]   SCR_OFFSET = AW'(15'h0000),
  parameter logic [AW-1:0]   OBJ_OFFSET = AW'(15'h4000)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          scr_cs,
  input  logic [13:0]   scr_addr,
  output logic [31:0]   scr_data,
  output logic          scr_ok,

  input  logic          obj_cs,
  input  logic [13:0]   obj_addr,
  output logic [31:0]   obj_data,
  output logic          obj_ok,

  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,

  output logic          busy
);

  typedef enum logic { IDLE = 1'b0, FETCH = 1'b1 } state_t;
  typedef enum logic { SEL_SCR = 1'b0, SEL_OBJ = 1'b1 } sel_t;

  state_t        state, state_nxt;
  sel_t          gnt_sel;        // requester currently being fetched
  logic [AW-1:0] gnt_addr;       // SDRAM address of the outstanding fetch
  logic [13:0]   gnt_tag;        // requester address latched at grant time

  logic [13:0]   scr_tag, obj_tag;
  logic          scr_vld, obj_vld;

  logic          scr_pend, obj_pend;
  logic          take;           // IDLE with something pending: grant now
  sel_t          pick;           // grantee chosen this cycle
  logic          fill;           // outstanding fetch completes this cycle

  // Offset addition truncates to AW bits, so the sum wraps around.
  logic [AW-1:0] scr_full, obj_full;
  assign scr_full = AW'(scr_addr) + SCR_OFFSET;
  assign obj_full = AW'(obj_addr) + OBJ_OFFSET;

  // Hits are combinational, so ok drops in the same cycle the address moves.
  assign scr_ok = scr_cs & scr_vld & (scr_tag == scr_addr);
  assign obj_ok = obj_cs & obj_vld & (obj_tag == obj_addr);

  // The requester being fetched is never pending, even if its address moved.
  assign scr_pend = scr_cs & ~scr_ok & ~((state == FETCH) & (gnt_sel == SEL_SCR));
  assign obj_pend = obj_cs & ~obj_ok & ~((state == FETCH) & (gnt_sel == SEL_OBJ));

  assign rom_cs   = (state == FETCH);
  assign rom_addr = gnt_addr;
  assign busy     = (state == FETCH);
  assign fill     = (state == FETCH) & rom_ok;

`ifdef JTTRACK_GFXARB_RR_EN
  sel_t last;   // most recent grantee; the other one wins a tie

  always_comb begin
    pick = (obj_pend & (~scr_pend | (last == SEL_SCR))) ? SEL_OBJ : SEL_SCR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= SEL_OBJ;
    else if (take) last <= pick;
  end
`else
  always_comb begin
    pick = (obj_pend & ~scr_pend) ? SEL_OBJ : SEL_SCR;
  end
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (scr_pend | obj_pend) begin
          take      = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (rom_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_sel  <= SEL_SCR;
      gnt_addr <= '0;
      gnt_tag  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        gnt_sel  <= pick;
        gnt_addr <= (pick == SEL_OBJ) ? obj_full : scr_full;
        gnt_tag  <= (pick == SEL_OBJ) ? obj_addr : scr_addr;
      end
    end
  end

  // NOTE: the one-entry caches are plain flops, so the data words are reset
  // along with tag and valid; reset therefore also invalidates both caches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_tag  <= '0;
      scr_vld  <= 1'b0;
      scr_data <= '0;
      obj_tag  <= '0;
      obj_vld  <= 1'b0;
      obj_data <= '0;
    end else if (fill) begin
      // The tag is the address latched at grant time: if the requester moved
      // on during the fetch, it misses and gets re-fetched from IDLE.
      if (gnt_sel == SEL_SCR) begin
        scr_tag  <= gnt_tag;
        scr_vld  <= 1'b1;
        scr_data <= rom_data;
      end else begin
        obj_tag  <= gnt_tag;
        obj_vld  <= 1'b1;
        obj_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_jttrack_gfx_arb.sv
// -----------------------------------------------------------------------------
// tb_jttrack_gfx_arb
//
// Self-checking bench for jttrack_gfx_arb (object offset overridden to 15'h4001
// so the address wrap can be observed). A transaction-level model keeps each
// requester's cached word and the arbitration history; SDRAM responses are
// produced by the bench with chosen latencies. Honours JTTRACK_GFXARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_jttrack_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scr_cs, obj_cs;
  logic [13:0] scr_addr, obj_addr;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic        rom_cs;
  logic [14:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Model: cached word per requester (0 = scroll, 1 = object), last grantee.
  bit          m_vld [2];
  logic [13:0] m_tag [2];
  logic [31:0] m_data[2];
  int          m_last = 1;

  jttrack_gfx_arb #(
    .AW        (15),
    .SCR_OFFSET(15'h0000),
    .OBJ_OFFSET(15'h4001)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scr_cs  (scr_cs),
    .scr_addr(scr_addr),
    .scr_data(scr_data),
    .scr_ok  (scr_ok),
    .obj_cs  (obj_cs),
    .obj_addr(obj_addr),
    .obj_data(obj_data),
    .obj_ok  (obj_ok),
    .rom_cs  (rom_cs),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rom_ok  (rom_ok),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] rom_exp(input int who, input logic [13:0] a);
    logic [14:0] s;
    s = (who == 0) ? {1'b0, a} : ({1'b0, a} + 15'h4001);
    return s;
  endfunction

  function automatic logic [31:0] mem(input logic [14:0] a);
    return (32'h9E3779B9 * {17'd0, a}) ^ 32'h1234_5678;
  endfunction

  function automatic int winner();
`ifdef JTTRACK_GFXARB_RR_EN
    return (m_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic ok_of(input int who);
    return (who == 0) ? scr_ok : obj_ok;
  endfunction

  function automatic logic [31:0] data_of(input int who);
    return (who == 0) ? scr_data : obj_data;
  endfunction

  // Expects one SDRAM fetch for requester 'who' at address 'a': rom_cs must
  // rise exactly one cycle after the call, the address must hold, and after
  // rom_ok the requester must be served (or not, if its address moved).
  task automatic serve(input int who, input logic [13:0] a, input logic [31:0] d,
                       input int dly, input bit expect_ok, input string name);
    int waited = 0;
    logic [14:0] ea;
    ea = rom_exp(who, a);
    while (!rom_cs && waited < 8) begin
      tick();
      waited++;
    end
    checks++;
    if (waited !== 1) begin
      errors++;
      $display("FAIL %s rom_cs delay: got %0d cycles, required 1", name, waited);
    end
    checks++;
    if (rom_addr !== ea) begin
      errors++;
      $display("FAIL %s rom_addr: got %h, required %h", name, rom_addr, ea);
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      checks++;
      if (rom_cs !== 1'b1 || busy !== 1'b1 || rom_addr !== ea) begin
        errors++;
        $display("FAIL %s hold: rom_cs=%b busy=%b rom_addr=%h, required 1 1 %h",
                 name, rom_cs, busy, rom_addr, ea);
      end
    end
    rom_ok   = 1'b1;
    rom_data = d;
    tick();
    rom_ok   = 1'b0;
    rom_data = $urandom;
    m_vld[who]  = 1'b1;
    m_tag[who]  = a;
    m_data[who] = d;
    m_last      = who;
    checks++;
    if (rom_cs !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: rom_cs=%b busy=%b, required 0 0", name, rom_cs, busy);
    end
    checks++;
    if (ok_of(who) !== expect_ok || (expect_ok && data_of(who) !== d)) begin
      errors++;
      $display("FAIL %s result: ok=%b data=%h, required ok=%b data=%h",
               name, ok_of(who), data_of(who), expect_ok, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scr_cs = 1'b1; scr_addr = 14'h0000; obj_cs = 1'b1; obj_addr = 14'h0000;
    rom_ok = 1'b0; rom_data = '0;
    repeat (3) tick();
    checks++;
    if (rom_cs !== 1'b0 || rom_addr !== 15'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset rom: rom_cs=%b rom_addr=%h busy=%b, required 0 0000 0",
               rom_cs, rom_addr, busy);
    end
    checks++;
    if (scr_ok !== 1'b0 || obj_ok !== 1'b0 || scr_data !== 32'h0 || obj_data !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: scr_ok=%b obj_ok=%b scr_data=%h obj_data=%h, required 0 0 0 0",
               scr_ok, obj_ok, scr_data, obj_data);
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_miss();
    scr_cs = 1'b1; scr_addr = 14'h0123;
    #1;
    checks++;
    if (scr_ok !== 1'b0) begin
      errors++;
      $display("FAIL single_miss pre: scr_ok=%b, required 0", scr_ok);
    end
    serve(0, 14'h0123, 32'hDEADBEEF, 3, 1'b1, "single_miss");
  endtask

  task automatic test_hit();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF || rom_cs !== 1'b0) begin
        errors++;
        $display("FAIL hit: scr_ok=%b scr_data=%h rom_cs=%b, required 1 deadbeef 0",
                 scr_ok, scr_data, rom_cs);
      end
      tick();
    end
    scr_cs = 1'b0;
    #1;
    checks++;
    if (scr_ok !== 1'b0) begin
      errors++;
      $display("FAIL hit drop: scr_ok=%b, required 0", scr_ok);
    end
    tick();
  endtask

  task automatic test_offset_wrap();
    obj_cs = 1'b1; obj_addr = 14'h3FFF;
    serve(1, 14'h3FFF, mem(15'h0000), 1, 1'b1, "offset_wrap");
    obj_cs = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int w;
    // A scroll grant first, so the round-robin build sees scroll as last.
    scr_cs = 1'b1; scr_addr = 14'h0300;
    serve(0, 14'h0300, mem(15'h0300), 0, 1'b1, "pre_contention");
    scr_cs = 1'b0;
    tick();
    scr_cs = 1'b1; scr_addr = 14'h0200;
    obj_cs = 1'b1; obj_addr = 14'h0201;
    w = winner();
    if (w == 0) begin
      serve(0, 14'h0200, 32'hA5A5_0200, 2, 1'b1, "contention_first");
      serve(1, 14'h0201, 32'h5A5A_0201, 1, 1'b1, "contention_second");
    end else begin
      serve(1, 14'h0201, 32'h5A5A_0201, 2, 1'b1, "contention_first");
      serve(0, 14'h0200, 32'hA5A5_0200, 1, 1'b1, "contention_second");
    end
    checks++;
    if (scr_ok !== 1'b1 || obj_ok !== 1'b1) begin
      errors++;
      $display("FAIL contention both: scr_ok=%b obj_ok=%b, required 1 1", scr_ok, obj_ok);
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    scr_cs = 1'b1; scr_addr = 14'h0010;
    tick();
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 15'h0010) begin
      errors++;
      $display("FAIL addr_change first: rom_cs=%b rom_addr=%h, required 1 0010", rom_cs, rom_addr);
    end
    scr_addr = 14'h0011;
    tick();
    rom_ok = 1'b1; rom_data = 32'h0000_0010;
    tick();
    rom_ok = 1'b0;
    m_vld[0] = 1'b1; m_tag[0] = 14'h0010; m_data[0] = 32'h0000_0010; m_last = 0;
    checks++;
    if (scr_ok !== 1'b0 || rom_cs !== 1'b0 || scr_data !== 32'h0000_0010) begin
      errors++;
      $display("FAIL addr_change stale: scr_ok=%b rom_cs=%b scr_data=%h, required 0 0 00000010",
               scr_ok, rom_cs, scr_data);
    end
    serve(0, 14'h0011, 32'h0000_0011, 1, 1'b1, "addr_change_refetch");
    scr_cs = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    obj_cs = 1'b1; obj_addr = m_tag[1];
    scr_cs = 1'b1; scr_addr = 14'h0400;
    tick();
    checks++;
    if (rom_cs !== 1'b1 || obj_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre: rom_cs=%b obj_ok=%b, required 1 1", rom_cs, obj_ok);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_cs !== 1'b0 || busy !== 1'b0 || scr_ok !== 1'b0 || obj_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: rom_cs=%b busy=%b scr_ok=%b obj_ok=%b, required 0 0 0 0",
               rom_cs, busy, scr_ok, obj_ok);
    end
    m_vld[0] = 1'b0; m_vld[1] = 1'b0; m_last = 1;
    obj_cs = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (scr_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid after: scr_ok=%b, required 0", scr_ok);
    end
    serve(0, 14'h0400, mem(15'h0400), 2, 1'b1, "reset_mid_refetch");
    scr_cs = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [13:0] pool[4];
    logic [13:0] sa, oa;
    bit se, oe, hs, ho, ms, mo;
    int w;
    pool[0] = 14'h0005; pool[1] = 14'h0006; pool[2] = 14'h3FFF; pool[3] = 14'h1234;
    for (int it = 0; it < 30; it++) begin
      se = 1'($urandom_range(0, 1));
      oe = 1'($urandom_range(0, 1));
      sa = pool[$urandom_range(0, 3)];
      oa = pool[$urandom_range(0, 3)];
      scr_cs = se; scr_addr = sa; obj_cs = oe; obj_addr = oa;
      #1;
      hs = se && m_vld[0] && (m_tag[0] == sa);
      ho = oe && m_vld[1] && (m_tag[1] == oa);
      checks++;
      if (scr_ok !== hs || (hs && scr_data !== m_data[0]) ||
          obj_ok !== ho || (ho && obj_data !== m_data[1])) begin
        errors++;
        $display("FAIL random hit it=%0d: scr_ok=%b obj_ok=%b, required %b %b",
                 it, scr_ok, obj_ok, hs, ho);
      end
      ms = se && !hs;
      mo = oe && !ho;
      if (ms && mo) begin
        w = winner();
        if (w == 0) begin
          serve(0, sa, mem(rom_exp(0, sa)), $urandom_range(0, 3), 1'b1, "random_both_scr");
          serve(1, oa, mem(rom_exp(1, oa)), $urandom_range(0, 3), 1'b1, "random_both_obj");
        end else begin
          serve(1, oa, mem(rom_exp(1, oa)), $urandom_range(0, 3), 1'b1, "random_both_obj");
          serve(0, sa, mem(rom_exp(0, sa)), $urandom_range(0, 3), 1'b1, "random_both_scr");
        end
      end else if (ms) begin
        serve(0, sa, mem(rom_exp(0, sa)), $urandom_range(0, 3), 1'b1, "random_scr");
      end else if (mo) begin
        serve(1, oa, mem(rom_exp(1, oa)), $urandom_range(0, 3), 1'b1, "random_obj");
      end else begin
        for (int i = 0; i < 2; i++) begin
          tick();
          checks++;
          if (rom_cs !== 1'b0) begin
            errors++;
            $display("FAIL random idle it=%0d: rom_cs=%b, required 0", it, rom_cs);
          end
        end
      end
      scr_cs = 1'b0; obj_cs = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_offset_wrap();
    test_contention();
    test_addr_change();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
